// File: rtl/lift_request_scheduler_if.sv
// Purpose: handshake between the request scheduler and the lift FSM.
//   lift_done : FSM idle and ready for the next request (FSM -> scheduler)
//   req_code  : 3-bit request code driven onto the FSM din (scheduler -> FSM)
//   q_empty   : no request offered, FSM holds (scheduler -> FSM)
interface lift_request_scheduler_if;
    logic       lift_done;
    logic [2:0] req_code;
    logic       q_empty;

    // Scheduler side
    modport master (
        input  lift_done,
        output req_code,
        output q_empty
    );

    // Lift FSM side
    modport slave (
        output lift_done,
        input  req_code,
        input  q_empty
    );
endinterface

// File: rtl/lift_request_scheduler.sv
// Purpose: collects hall calls of a 4-floor lift into a pending mask and feeds
// them one at a time to the lift FSM using a sweep (SCAN) policy: the current
// travel direction is kept while calls remain in it.
// Ports:
//   clk          : clock, all logic on posedge
//   rst          : synchronous reset, active-high
//   call_btn     : hall calls, bit0=1U bit1=2U bit2=3U bit3=2D bit4=3D bit5=4D
//   lift         : handshake to the lift FSM (lift_done in; req_code, q_empty out)
//   pending      : registered pending-call mask, same bit map as call_btn
//   served_count : requests accepted by the FSM, wraps at 2^CNT_W
//   err_timeout  : sticky flag, set when an issued request is never accepted
module lift_request_scheduler #(
    parameter int unsigned ACK_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 8,
    parameter bit          EDGE_DET    = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               call_btn,
    lift_request_scheduler_if.master lift,
    output logic [5:0]               pending,
    output logic [CNT_W-1:0]         served_count,
    output logic                     err_timeout
);

    localparam int unsigned NCALL = 6;
    localparam int unsigned IDX_W = 3;
    localparam int unsigned TMR_W = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_DONE
    } state_t;

    state_t             state_q;
    logic [NCALL-1:0]   pending_q;
    logic [NCALL-1:0]   pending_d;
    logic [NCALL-1:0]   btn_q;
    logic [NCALL-1:0]   set_vec;
    logic [NCALL-1:0]   clr_vec;
    logic               dir_up_q;
    logic [IDX_W-1:0]   sel_q;
    logic [IDX_W-1:0]   sel_d;
    logic [IDX_W-1:0]   up_idx;
    logic [IDX_W-1:0]   dn_idx;
    logic               up_any;
    logic               dn_any;
    logic [TMR_W-1:0]   tmr_q;
    logic [2:0]         req_code_q;
    logic               q_empty_q;
    logic [CNT_W-1:0]   served_q;
    logic               err_q;

    // Request code seen by the FSM for each pending-mask index.
    function automatic logic [2:0] code_of(input logic [IDX_W-1:0] idx);
        logic [2:0] code;
        case (idx)
            3'd0:    code = 3'b001;  // 1U
            3'd1:    code = 3'b010;  // 2U
            3'd2:    code = 3'b011;  // 3U
            3'd3:    code = 3'b110;  // 2D
            3'd4:    code = 3'b111;  // 3D
            3'd5:    code = 3'b100;  // 4D
            default: code = 3'b000;
        endcase
        return code;
    endfunction

    // Call capture: edge mode turns a held button into a single call.
    always_comb begin
        set_vec = call_btn;
        if (EDGE_DET) begin
            set_vec = call_btn & ~btn_q;
        end
    end

    // Acceptance of the issued call clears its bit; a same-cycle set wins.
    always_comb begin
        clr_vec = '0;
        if (state_q == S_ISSUE && !lift.lift_done) begin
            clr_vec = NCALL'(1) << sel_q;
        end
        pending_d = (pending_q & ~clr_vec) | set_vec;
    end

    // SCAN selection: first call in the current direction, else the other one.
    always_comb begin
        up_any = |pending_q[2:0];
        dn_any = |pending_q[5:3];

        if (pending_q[0])      up_idx = 3'd0;
        else if (pending_q[1]) up_idx = 3'd1;
        else                   up_idx = 3'd2;

        if (pending_q[5])      dn_idx = 3'd5;
        else if (pending_q[4]) dn_idx = 3'd4;
        else                   dn_idx = 3'd3;

        if (dir_up_q) sel_d = up_any ? up_idx : dn_idx;
        else          sel_d = dn_any ? dn_idx : up_idx;
    end

    // Controller: state, selection latch, timer, counters and registered
    // FSM-facing outputs, which always take the value of the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pending_q  <= '0;
            btn_q      <= '0;
            dir_up_q   <= 1'b1;
            sel_q      <= '0;
            tmr_q      <= '0;
            req_code_q <= 3'b000;
            q_empty_q  <= 1'b1;
            served_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            btn_q     <= call_btn;
            pending_q <= pending_d;

            case (state_q)
                S_IDLE: begin
                    req_code_q <= 3'b000;
                    q_empty_q  <= (pending_d == '0);
                    if (pending_q != '0 && lift.lift_done) begin
                        state_q    <= S_ISSUE;
                        sel_q      <= sel_d;
                        dir_up_q   <= (sel_d < 3'd3);
                        tmr_q      <= '0;
                        req_code_q <= code_of(sel_d);
                        q_empty_q  <= 1'b0;
                    end
                end

                S_ISSUE: begin
                    if (!lift.lift_done) begin
                        // FSM went busy: request accepted.
                        state_q    <= S_WAIT_DONE;
                        served_q   <= served_q + CNT_W'(1);
                        req_code_q <= 3'b000;
                        q_empty_q  <= 1'b1;
                    end else if (tmr_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                        // Never accepted: abort, keep the call pending.
                        state_q    <= S_IDLE;
                        err_q      <= 1'b1;
                        req_code_q <= 3'b000;
                        q_empty_q  <= (pending_d == '0);
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end

                S_WAIT_DONE: begin
                    // FSM ignores din while busy, so present an empty queue.
                    req_code_q <= 3'b000;
                    q_empty_q  <= 1'b1;
                    if (lift.lift_done) begin
                        state_q   <= S_IDLE;
                        q_empty_q <= (pending_d == '0);
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    req_code_q <= 3'b000;
                    q_empty_q  <= 1'b1;
                end
            endcase
        end
    end

    assign lift.req_code = req_code_q;
    assign lift.q_empty  = q_empty_q;
    assign pending       = pending_q;
    assign served_count  = served_q;
    assign err_timeout   = err_q;

endmodule
